imem_uart_loader: RTL and testbench

- Serial program loader. Receives a framed instruction image on UART_RXD and writes it word-by-word into the instruction memory's write port.
- It is the writer side of the instruction memory; the processor datapath is the reader.
- Sits at the top level next to the instruction memory. `busy` holds the program counter in reset while a load is in progress.

---
 rtl/imem_uart_loader_pkg.sv | 29 ++
 rtl/imem_uart_loader_uart_rx_byte.sv | 97 +++++++++
 rtl/imem_uart_loader.sv | 131 +++++++++++++
 tb/tb_imem_uart_loader.sv | 272 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/imem_uart_loader_pkg.sv
// Shared types and timing helpers for the UART instruction-memory loader.
package imem_uart_loader_pkg;

    typedef enum logic [1:0] {
        L_IDLE,
        L_COUNT,
        L_DATA,
        L_CHK
    } load_state_t;

    typedef enum logic [1:0] {
        R_IDLE,
        R_START,
        R_DATA,
        R_STOP
    } rx_state_t;

    localparam logic [7:0] SYNC_BYTE = 8'hA5;

    function automatic int calc_clks_per_bit(input int clk_hz, input int baud);
        return clk_hz / baud;
    endfunction

    // One byte time is 10 bit times (start + 8 data + stop).
    function automatic int calc_timeout_limit(input int bytes, input int cpb);
        return bytes * 10 * cpb;
    endfunction

endpackage

// File: rtl/imem_uart_loader_uart_rx_byte.sv
// 8N1 UART byte receiver: rx synchronizer, start-bit glitch filter,
// mid-bit sampling, one-cycle byte_valid / frame_err pulses.
module uart_rx_byte
    import imem_uart_loader_pkg::*;
#(
    parameter int CLKS_PER_BIT = 434
) (
    input  logic       i_clk,
    input  logic       i_rst,
    input  logic       i_rx,
    output logic       o_byte_valid,
    output logic [7:0] o_data,
    output logic       o_frame_err
);

    localparam int CNT_W = $clog2(CLKS_PER_BIT + 1);
    localparam logic [CNT_W-1:0] HALF_M1 = CNT_W'(CLKS_PER_BIT / 2 - 1);
    localparam logic [CNT_W-1:0] FULL_M1 = CNT_W'(CLKS_PER_BIT - 1);

    logic             r_sync1;
    logic             r_sync2;
    logic             r_prev;
    rx_state_t        r_state;
    logic [CNT_W-1:0] r_cnt;
    logic [2:0]       r_bit;
    logic [7:0]       r_shift;
    logic             w_fall;

    assign w_fall = r_prev & ~r_sync2;

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_sync1      <= 1'b1;
            r_sync2      <= 1'b1;
            r_prev       <= 1'b1;
            r_state      <= R_IDLE;
            r_cnt        <= '0;
            r_bit        <= '0;
            r_shift      <= '0;
            o_byte_valid <= 1'b0;
            o_data       <= '0;
            o_frame_err  <= 1'b0;
        end else begin
            r_sync1      <= i_rx;
            r_sync2      <= r_sync1;
            r_prev       <= r_sync2;
            o_byte_valid <= 1'b0;
            o_frame_err  <= 1'b0;
            unique case (r_state)
                R_IDLE: begin
                    if (w_fall) begin
                        r_cnt   <= '0;
                        r_state <= R_START;
                    end
                end
                R_START: begin
                    if (r_cnt == HALF_M1) begin
                        r_cnt   <= '0;
                        r_bit   <= '0;
                        // Line back high at mid start bit: treat as a glitch.
                        r_state <= r_sync2 ? R_IDLE : R_DATA;
                    end else begin
                        r_cnt <= r_cnt + 1'b1;
                    end
                end
                R_DATA: begin
                    if (r_cnt == FULL_M1) begin
                        r_cnt   <= '0;
                        r_shift <= {r_sync2, r_shift[7:1]};
                        r_bit   <= r_bit + 1'b1;
                        if (r_bit == 3'd7) begin
                            r_state <= R_STOP;
                        end
                    end else begin
                        r_cnt <= r_cnt + 1'b1;
                    end
                end
                R_STOP: begin
                    if (r_cnt == FULL_M1) begin
                        r_cnt   <= '0;
                        r_state <= R_IDLE;
                        if (r_sync2) begin
                            o_byte_valid <= 1'b1;
                            o_data       <= r_shift;
                        end else begin
                            o_frame_err <= 1'b1;
                        end
                    end else begin
                        r_cnt <= r_cnt + 1'b1;
                    end
                end
                default: r_state <= R_IDLE;
            endcase
        end
    end

endmodule

// File: rtl/imem_uart_loader.sv
// Serial program loader: parses A5/N/data/CHK frames from the UART and
// drives the instruction memory write port word by word.
module imem_uart_loader
    import imem_uart_loader_pkg::*;
#(
    parameter int CLK_HZ        = 50000000,
    parameter int BAUD          = 115200,
    parameter int ADDR_W        = 8,
    parameter int TIMEOUT_BYTES = 16
) (
    input  logic              clock_reg,
    input  logic              reset,
    input  logic              rx,
    output logic              imem_we,
    output logic [ADDR_W-1:0] imem_addr,
    output logic [31:0]       imem_wdata,
    output logic              busy,
    output logic              done,
    output logic              error,
    output logic [6:0]        words_loaded
);

    localparam int CPB       = calc_clks_per_bit(CLK_HZ, BAUD);
    localparam int TO_LIMIT  = calc_timeout_limit(TIMEOUT_BYTES, CPB);
    localparam int TO_W      = $clog2(TO_LIMIT + 1);
    localparam int MAX_WORDS = (2 ** ADDR_W) / 4;

    logic            w_byte_valid;
    logic [7:0]      w_data;
    logic            w_frame_err;
    logic            w_timeout;

    load_state_t     r_state;
    logic [7:0]      r_count;
    logic [7:0]      r_chk;
    logic [1:0]      r_idx;
    logic [23:0]     r_word;
    logic [TO_W-1:0] r_to_cnt;

    uart_rx_byte #(
        .CLKS_PER_BIT(CPB)
    ) u_rx (
        .i_clk       (clock_reg),
        .i_rst       (reset),
        .i_rx        (rx),
        .o_byte_valid(w_byte_valid),
        .o_data      (w_data),
        .o_frame_err (w_frame_err)
    );

    assign w_timeout = (r_to_cnt == TO_W'(TO_LIMIT)) && (r_state != L_IDLE);

    always_ff @(posedge clock_reg or posedge reset) begin
        if (reset) begin
            r_state      <= L_IDLE;
            r_count      <= '0;
            r_chk        <= '0;
            r_idx        <= '0;
            r_word       <= '0;
            r_to_cnt     <= '0;
            imem_we      <= 1'b0;
            imem_addr    <= '0;
            imem_wdata   <= '0;
            busy         <= 1'b0;
            done         <= 1'b0;
            error        <= 1'b0;
            words_loaded <= '0;
        end else begin
            imem_we <= 1'b0;
            done    <= 1'b0;
            if (w_byte_valid || r_state == L_IDLE) begin
                r_to_cnt <= '0;
            end else begin
                r_to_cnt <= r_to_cnt + 1'b1;
            end
            // A byte arriving in the expiry cycle takes priority over the timeout.
            if (w_byte_valid) begin
                unique case (r_state)
                    L_IDLE: begin
                        if (w_data == SYNC_BYTE) begin
                            error        <= 1'b0;
                            words_loaded <= '0;
                            r_chk        <= '0;
                            r_idx        <= '0;
                            r_state      <= L_COUNT;
                        end
                    end
                    L_COUNT: begin
                        if (w_data == 8'd0 || int'(w_data) > MAX_WORDS) begin
                            error   <= 1'b1;
                            r_state <= L_IDLE;
                        end else begin
                            r_count <= w_data;
                            busy    <= 1'b1;
                            r_state <= L_DATA;
                        end
                    end
                    L_DATA: begin
                        r_chk  <= r_chk ^ w_data;
                        r_idx  <= r_idx + 1'b1;
                        r_word <= {w_data, r_word[23:8]};
                        if (r_idx == 2'd3) begin
                            imem_we      <= 1'b1;
                            imem_addr    <= ADDR_W'({words_loaded, 2'b00});
                            imem_wdata   <= {w_data, r_word};
                            words_loaded <= words_loaded + 1'b1;
                            if (8'(words_loaded) + 8'd1 == r_count) begin
                                r_state <= L_CHK;
                            end
                        end
                    end
                    L_CHK: begin
                        busy    <= 1'b0;
                        r_state <= L_IDLE;
                        if (w_data == r_chk) begin
                            done <= 1'b1;
                        end else begin
                            error <= 1'b1;
                        end
                    end
                    default: r_state <= L_IDLE;
                endcase
            end else if ((w_frame_err || w_timeout) && r_state != L_IDLE) begin
                error   <= 1'b1;
                busy    <= 1'b0;
                r_state <= L_IDLE;
            end
        end
    end

endmodule

// File: tb/tb_imem_uart_loader.sv
// Directed bench for imem_uart_loader: frame table plus corner sequences.
module tb_imem_uart_loader;

    localparam int CPB = 16;

    logic        clock_reg = 1'b0;
    logic        reset = 1'b1;
    logic        rx = 1'b1;
    logic        imem_we;
    logic [7:0]  imem_addr;
    logic [31:0] imem_wdata;
    logic        busy;
    logic        done;
    logic        error;
    logic [6:0]  words_loaded;

    int n_tests = 0;
    int n_fail = 0;

    imem_uart_loader #(
        .CLK_HZ       (1600000),
        .BAUD         (100000),
        .ADDR_W       (8),
        .TIMEOUT_BYTES(16)
    ) dut (
        .clock_reg   (clock_reg),
        .reset       (reset),
        .rx          (rx),
        .imem_we     (imem_we),
        .imem_addr   (imem_addr),
        .imem_wdata  (imem_wdata),
        .busy        (busy),
        .done        (done),
        .error       (error),
        .words_loaded(words_loaded)
    );

    always #5 clock_reg = ~clock_reg;

    logic [7:0]  wa_q [$];
    logic [31:0] wd_q [$];
    int   done_cnt = 0;
    int   rise_cnt = 0;
    int   clash_cnt = 0;
    int   done_busy_cnt = 0;
    logic prev_busy = 1'b0;

    always @(negedge clock_reg) begin
        if (imem_we) begin
            wa_q.push_back(imem_addr);
            wd_q.push_back(imem_wdata);
        end
        if (done) done_cnt++;
        if (done && error) clash_cnt++;
        if (done && busy) done_busy_cnt++;
        if (busy && !prev_busy) rise_cnt++;
        prev_busy = busy;
    end

    typedef struct {
        logic [95:0] raw;
        int          n;
        int          nw;
        logic [7:0]  a0;
        logic [31:0] d0;
        logic [7:0]  a1;
        logic [31:0] d1;
        int          nd;
        logic        err;
        int          wl;
        int          rose;
    } vec_t;

    vec_t vecs [7];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge clock_reg);
        #1;
    endtask

    task automatic send_byte(input logic [7:0] b, input logic stop_bit);
        rx = 1'b0;
        tick(CPB);
        for (int i = 0; i < 8; i++) begin
            rx = b[i];
            tick(CPB);
        end
        rx = stop_bit;
        tick(CPB);
        rx = 1'b1;
    endtask

    task automatic send_frame(input logic [95:0] raw, input int n);
        for (int i = 0; i < n; i++) begin
            send_byte(raw[8*(n-1-i) +: 8], 1'b1);
        end
    endtask

    task automatic set_vec(input int k, input logic [95:0] raw, input int n,
                           input int nw, input logic [7:0] a0, input logic [31:0] d0,
                           input logic [7:0] a1, input logic [31:0] d1,
                           input int nd, input logic err, input int wl, input int rose);
        vecs[k].raw  = raw;
        vecs[k].n    = n;
        vecs[k].nw   = nw;
        vecs[k].a0   = a0;
        vecs[k].d0   = d0;
        vecs[k].a1   = a1;
        vecs[k].d1   = d1;
        vecs[k].nd   = nd;
        vecs[k].err  = err;
        vecs[k].wl   = wl;
        vecs[k].rose = rose;
    endtask

    task automatic run_vec(input int k);
        int wb;
        int db;
        int rb;
        wb = wa_q.size();
        db = done_cnt;
        rb = rise_cnt;
        send_frame(vecs[k].raw, vecs[k].n);
        tick(24);
        chk($sformatf("v%0d nwrites", k), wa_q.size() - wb, vecs[k].nw);
        if (vecs[k].nw > 0 && wa_q.size() > wb) begin
            chk($sformatf("v%0d addr0", k), wa_q[wb], vecs[k].a0);
            chk($sformatf("v%0d data0", k), wd_q[wb], vecs[k].d0);
        end
        if (vecs[k].nw > 1 && wa_q.size() > wb + 1) begin
            chk($sformatf("v%0d addr1", k), wa_q[wb+1], vecs[k].a1);
            chk($sformatf("v%0d data1", k), wd_q[wb+1], vecs[k].d1);
        end
        if (vecs[k].nw == 1) begin
            chk($sformatf("v%0d addr held", k), imem_addr, vecs[k].a0);
            chk($sformatf("v%0d data held", k), imem_wdata, vecs[k].d0);
        end
        if (vecs[k].nw == 2) begin
            chk($sformatf("v%0d addr held", k), imem_addr, vecs[k].a1);
            chk($sformatf("v%0d data held", k), imem_wdata, vecs[k].d1);
        end
        chk($sformatf("v%0d done pulses", k), done_cnt - db, vecs[k].nd);
        chk($sformatf("v%0d error", k), error, vecs[k].err);
        chk($sformatf("v%0d words_loaded", k), words_loaded, vecs[k].wl);
        chk($sformatf("v%0d busy end", k), busy, 0);
        chk($sformatf("v%0d busy rises", k), rise_cnt - rb, vecs[k].rose);
    endtask

    initial begin
        #(10 * 200000);
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int wb;
        int db;
        int waited;

        set_vec(0, 96'hA5_01_13_00_00_00_13, 7, 1, 8'h00, 32'h00000013,
                8'h00, 32'h0, 1, 1'b0, 1, 1);
        set_vec(1, 96'hA5_02_93_00_50_00_13_01_10_00_C1, 11, 2, 8'h00, 32'h00500093,
                8'h04, 32'h00100113, 1, 1'b0, 2, 1);
        set_vec(2, 96'hA5_02_93_00_50_00_13_01_10_00_C0, 11, 2, 8'h00, 32'h00500093,
                8'h04, 32'h00100113, 0, 1'b1, 2, 1);
        set_vec(3, 96'hA5_01_13_00_00_00_13, 7, 1, 8'h00, 32'h00000013,
                8'h00, 32'h0, 1, 1'b0, 1, 1);
        set_vec(4, 96'hA5_00, 2, 0, 8'h00, 32'h0, 8'h00, 32'h0, 0, 1'b1, 0, 0);
        set_vec(5, 96'hA5_41, 2, 0, 8'h00, 32'h0, 8'h00, 32'h0, 0, 1'b1, 0, 0);
        set_vec(6, 96'h00_FF_A5_01_78_56_34_12_08, 9, 1, 8'h00, 32'h12345678,
                8'h00, 32'h0, 1, 1'b0, 1, 1);

        // Reset state
        tick(4);
        chk("reset imem_we", imem_we, 0);
        chk("reset imem_addr", imem_addr, 0);
        chk("reset imem_wdata", imem_wdata, 0);
        chk("reset busy", busy, 0);
        chk("reset done", done, 0);
        chk("reset error", error, 0);
        chk("reset words_loaded", words_loaded, 0);
        reset = 1'b0;
        tick(10);

        for (int k = 0; k < 7; k++) begin
            run_vec(k);
        end

        // Start-bit glitch inside a frame must not produce a byte
        wb = wa_q.size();
        db = done_cnt;
        send_frame(96'hA5_01, 2);
        rx = 1'b0;
        tick(4);
        rx = 1'b1;
        tick(40);
        send_frame(96'h13_00_00_00_13, 5);
        tick(24);
        chk("glitch nwrites", wa_q.size() - wb, 1);
        if (wa_q.size() > wb) chk("glitch data", wd_q[wb], 32'h00000013);
        chk("glitch done", done_cnt - db, 1);
        chk("glitch error", error, 0);

        // Stop bit low on data byte 2
        wb = wa_q.size();
        send_frame(96'hA5_01_13, 3);
        send_byte(8'h00, 1'b0);
        tick(4);
        chk("stopbit error", error, 1);
        chk("stopbit busy", busy, 0);
        chk("stopbit fsm idle", 32'(dut.r_state), 0);
        chk("stopbit nwrites", wa_q.size() - wb, 0);
        tick(20);

        // Inter-byte timeout
        send_frame(96'hA5_01_13, 3);
        chk("timeout error cleared", error, 0);
        tick(2450);
        chk("timeout early error", error, 0);
        chk("timeout early busy", busy, 1);
        waited = 2450;
        for (int i = 0; i < 300; i++) begin
            if (error) break;
            tick(1);
            waited++;
        end
        chk("timeout error", error, 1);
        chk("timeout busy", busy, 0);
        if (waited < 2540 || waited > 2575) begin
            n_tests++;
            n_fail++;
            $display("FAIL timeout delay: got %0d cycles, expected about 2557", waited);
        end else begin
            n_tests++;
        end

        // Reset in the middle of L_DATA
        send_frame(96'hA5_02_93_00_50_00, 6);
        tick(4);
        chk("midreset pre busy", busy, 1);
        chk("midreset pre words", words_loaded, 1);
        @(negedge clock_reg);
        reset = 1'b1;
        #1;
        chk("midreset imem_we", imem_we, 0);
        chk("midreset imem_addr", imem_addr, 0);
        chk("midreset imem_wdata", imem_wdata, 0);
        chk("midreset busy", busy, 0);
        chk("midreset done", done, 0);
        chk("midreset error", error, 0);
        chk("midreset words_loaded", words_loaded, 0);
        tick(3);
        reset = 1'b0;
        tick(10);
        run_vec(0);

        chk("done with error", clash_cnt, 0);
        chk("done with busy", done_busy_cnt, 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
